// File: rtl/sm4_key_expansion.sv
// rtl/sm4_key_expansion.sv - SM4 key schedule: 128-bit cipher key to 32 registered round keys
module sm4_key_expansion #(
    parameter int ROUNDS_PER_CYCLE = 1,
    parameter bit CLEAR_ON_START   = 1'b1
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         sm4_enable_in,
    input  logic         key_exp_enable_in,
    input  logic         dec_sel_in,
    input  logic [127:0] key_in,
    output logic [31:0]  rk_00_out,
    output logic [31:0]  rk_01_out,
    output logic [31:0]  rk_02_out,
    output logic [31:0]  rk_03_out,
    output logic [31:0]  rk_04_out,
    output logic [31:0]  rk_05_out,
    output logic [31:0]  rk_06_out,
    output logic [31:0]  rk_07_out,
    output logic [31:0]  rk_08_out,
    output logic [31:0]  rk_09_out,
    output logic [31:0]  rk_10_out,
    output logic [31:0]  rk_11_out,
    output logic [31:0]  rk_12_out,
    output logic [31:0]  rk_13_out,
    output logic [31:0]  rk_14_out,
    output logic [31:0]  rk_15_out,
    output logic [31:0]  rk_16_out,
    output logic [31:0]  rk_17_out,
    output logic [31:0]  rk_18_out,
    output logic [31:0]  rk_19_out,
    output logic [31:0]  rk_20_out,
    output logic [31:0]  rk_21_out,
    output logic [31:0]  rk_22_out,
    output logic [31:0]  rk_23_out,
    output logic [31:0]  rk_24_out,
    output logic [31:0]  rk_25_out,
    output logic [31:0]  rk_26_out,
    output logic [31:0]  rk_27_out,
    output logic [31:0]  rk_28_out,
    output logic [31:0]  rk_29_out,
    output logic [31:0]  rk_30_out,
    output logic [31:0]  rk_31_out,
    output logic         key_exp_ready_out,
    output logic         busy_out
);
    typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_t;

    localparam logic [127:0] FK = 128'hA3B1BAC6_56AA3350_677D9197_B27022DC;
    // First byte written is entry 255, so S-box entry x lives at SBOX[~x].
    localparam logic [255:0][7:0] SBOX = {
        128'hd690e9fecce13db716b614c228fb2c05, 128'h2b679a762abe04c3aa44132649860699,
        128'h9c4250f491ef987a33540b43edcfac62, 128'he4b31ca9c908e89580df94fa758f3fa6,
        128'h4707a7fcf37317ba83593c19e6854fa8, 128'h686b81b27164da8bf8eb0f4b70569d35,
        128'h1e240e5e6358d1a225227c3b01217887, 128'hd40046579fd327524c3602e7a0c4c89e,
        128'heabf8ad240c738b5a3f7f2cef96115a1, 128'he0ae5da49b341a55ad933230f58cb1e3,
        128'h1df6e22e8266ca60c02923ab0d534e6f, 128'hd5db3745defd8e2f03ff6a726d6c5b51,
        128'h8d1baf92bbddbc7f11d95c411f105ad8, 128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
        128'h8969974a0c96777e65b9f109c56ec684, 128'h18f07dec3adc4d2079ee5f3ed7cb3948
    };

    function automatic logic [31:0] t_prime(input logic [31:0] x);
        logic [31:0] b;
        for (int j = 0; j < 4; j++) b[8*j +: 8] = SBOX[~x[8*j +: 8]];
        return b ^ {b[18:0], b[31:19]} ^ {b[8:0], b[31:9]};
    endfunction

    function automatic logic [31:0] ck(input logic [4:0] i);
        logic [31:0] c;
        for (int j = 0; j < 4; j++) c[31-8*j -: 8] = 8'((4 * int'(i) + j) * 7);
        return c;
    endfunction

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        dec_q, dec_d;
    logic [31:0] k_q [4];
    logic [31:0] k_d [4];
    logic [31:0] rk_q [32];
    logic [31:0] rk_d [32];
    logic [31:0] w [4];
    logic [31:0] nk;
    logic [31:0] rk_map [32];
    logic        last_step;

    assign last_step = ({1'b0, cnt_q} + 6'(ROUNDS_PER_CYCLE)) == 6'd32;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dec_q   <= 1'b0;
            for (int i = 0; i < 4; i++) k_q[i] <= '0;
            for (int i = 0; i < 32; i++) rk_q[i] <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dec_q   <= dec_d;
            k_q     <= k_d;
            rk_q    <= rk_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (sm4_enable_in) begin
            unique case (state_q)
                IDLE:    if (key_exp_enable_in) state_d = EXPAND;
                EXPAND:  if (!key_exp_enable_in) state_d = IDLE;
                         else if (last_step) state_d = DONE;
                DONE:    if (!key_exp_enable_in) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Working window w[0..3] holds K[i..i+3]; each round shifts in K[i+4], which is also rk[i].
    always_comb begin
        cnt_d = cnt_q;
        dec_d = dec_q;
        k_d   = k_q;
        rk_d  = rk_q;
        w     = k_q;
        nk    = '0;
        if (sm4_enable_in && key_exp_enable_in) begin
            if (state_q == IDLE) begin
                for (int i = 0; i < 4; i++) k_d[i] = key_in[127-32*i -: 32] ^ FK[127-32*i -: 32];
                dec_d = dec_sel_in;
                cnt_d = '0;
                if (CLEAR_ON_START) for (int i = 0; i < 32; i++) rk_d[i] = '0;
            end else if (state_q == EXPAND) begin
                for (int r = 0; r < ROUNDS_PER_CYCLE; r++) begin
                    nk = w[0] ^ t_prime(w[1] ^ w[2] ^ w[3] ^ ck(cnt_q + 5'(r)));
                    rk_d[cnt_q + 5'(r)] = nk;
                    w[0] = w[1];
                    w[1] = w[2];
                    w[2] = w[3];
                    w[3] = nk;
                end
                k_d = w;
                if (!last_step) cnt_d = cnt_q + 5'(ROUNDS_PER_CYCLE);
            end
        end
    end

    always_comb begin
        key_exp_ready_out = (state_q == DONE);
        busy_out          = (state_q == EXPAND);
        for (int j = 0; j < 32; j++) rk_map[j] = dec_q ? rk_q[31-j] : rk_q[j];
    end

    assign rk_00_out = rk_map[0];
    assign rk_01_out = rk_map[1];
    assign rk_02_out = rk_map[2];
    assign rk_03_out = rk_map[3];
    assign rk_04_out = rk_map[4];
    assign rk_05_out = rk_map[5];
    assign rk_06_out = rk_map[6];
    assign rk_07_out = rk_map[7];
    assign rk_08_out = rk_map[8];
    assign rk_09_out = rk_map[9];
    assign rk_10_out = rk_map[10];
    assign rk_11_out = rk_map[11];
    assign rk_12_out = rk_map[12];
    assign rk_13_out = rk_map[13];
    assign rk_14_out = rk_map[14];
    assign rk_15_out = rk_map[15];
    assign rk_16_out = rk_map[16];
    assign rk_17_out = rk_map[17];
    assign rk_18_out = rk_map[18];
    assign rk_19_out = rk_map[19];
    assign rk_20_out = rk_map[20];
    assign rk_21_out = rk_map[21];
    assign rk_22_out = rk_map[22];
    assign rk_23_out = rk_map[23];
    assign rk_24_out = rk_map[24];
    assign rk_25_out = rk_map[25];
    assign rk_26_out = rk_map[26];
    assign rk_27_out = rk_map[27];
    assign rk_28_out = rk_map[28];
    assign rk_29_out = rk_map[29];
    assign rk_30_out = rk_map[30];
    assign rk_31_out = rk_map[31];
endmodule
